// File: rtl/arbitro_acesso_if.sv
// rtl/arbitro_acesso_if.sv - request/grant bundle between the two institutions and the arbiter
interface arbitro_acesso_if;
   logic       REQ_IE01;
   logic       REQ_IE02;
   logic [1:0] PERF_IE01;
   logic [1:0] PERF_IE02;
   logic       DONE_IE01;
   logic       DONE_IE02;
   logic       GNT_IE01;
   logic       GNT_IE02;
   logic       BUSY;
   logic       TIMEOUT_FLAG;
   logic       LED_r;
   logic       LED_g;
   logic       LED_b;

   modport master (
      output REQ_IE01, REQ_IE02, PERF_IE01, PERF_IE02, DONE_IE01, DONE_IE02,
      input  GNT_IE01, GNT_IE02, BUSY, TIMEOUT_FLAG, LED_r, LED_g, LED_b
   );

   modport slave (
      input  REQ_IE01, REQ_IE02, PERF_IE01, PERF_IE02, DONE_IE01, DONE_IE02,
      output GNT_IE01, GNT_IE02, BUSY, TIMEOUT_FLAG, LED_r, LED_g, LED_b
   );
endinterface

// File: rtl/arbitro_acesso.sv
// rtl/arbitro_acesso.sv - two-requester profile-priority access arbiter with hold limit
module arbitro_acesso #(
   parameter int TIMEOUT = 15,
   parameter int CNT_W   = 4
) (
   input  logic              clk,
   input  logic              reset,
   arbitro_acesso_if.slave   bus
);
   typedef enum logic [1:0] {IDLE, GRANT1, GRANT2, RELEASE} state_t;

   localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(TIMEOUT - 1);

   state_t           state;
   logic [CNT_W-1:0] hold_cnt;
   logic             last_served;   // 0 = IE01, 1 = IE02
   logic             gnt1_q, gnt2_q, busy_q, flag_q;
   logic [2:0]       led_q;         // {r, g, b}

   logic             arb_go, arb_pick2, arb_cmp;
   logic [2:0]       arb_led;
   logic             hold_done;
   logic             quit1, quit2, expire1, expire2;

   always_comb begin
      arb_go    = 1'b0;
      arb_pick2 = 1'b0;
      arb_cmp   = 1'b0;
      arb_led   = 3'b000;
      if (bus.REQ_IE01 && bus.REQ_IE02) begin
         arb_go  = 1'b1;
         arb_cmp = 1'b1;
         if (bus.PERF_IE01 > bus.PERF_IE02) begin
            arb_pick2 = 1'b0;
            arb_led   = 3'b001;
         end else if (bus.PERF_IE01 < bus.PERF_IE02) begin
            arb_pick2 = 1'b1;
            arb_led   = 3'b100;
         end else begin
            // Tie goes to whoever was not served last.
            arb_pick2 = ~last_served;
            arb_led   = 3'b010;
         end
      end else if (bus.REQ_IE01) begin
         arb_go    = 1'b1;
         arb_pick2 = 1'b0;
      end else if (bus.REQ_IE02) begin
         arb_go    = 1'b1;
         arb_pick2 = 1'b1;
      end
   end

   assign hold_done = (hold_cnt == HOLD_MAX);
   assign quit1     = bus.DONE_IE01 | ~bus.REQ_IE01 | hold_done;
   assign quit2     = bus.DONE_IE02 | ~bus.REQ_IE02 | hold_done;
   assign expire1   = hold_done & ~bus.DONE_IE01 & bus.REQ_IE01;
   assign expire2   = hold_done & ~bus.DONE_IE02 & bus.REQ_IE02;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         hold_cnt    <= '0;
         last_served <= 1'b1;
         gnt1_q      <= 1'b0;
         gnt2_q      <= 1'b0;
         busy_q      <= 1'b0;
         flag_q      <= 1'b0;
         led_q       <= 3'b000;
      end else begin
         flag_q <= 1'b0;
         case (state)
            IDLE, RELEASE: begin
               if (arb_go) begin
                  state       <= arb_pick2 ? GRANT2 : GRANT1;
                  gnt1_q      <= ~arb_pick2;
                  gnt2_q      <= arb_pick2;
                  busy_q      <= 1'b1;
                  hold_cnt    <= '0;
                  last_served <= arb_pick2;
                  if (arb_cmp) led_q <= arb_led;
               end else begin
                  state  <= IDLE;
                  gnt1_q <= 1'b0;
                  gnt2_q <= 1'b0;
                  busy_q <= 1'b0;
               end
            end
            GRANT1: begin
               if (quit1) begin
                  state  <= RELEASE;
                  gnt1_q <= 1'b0;
                  busy_q <= 1'b0;
                  flag_q <= expire1;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            GRANT2: begin
               if (quit2) begin
                  state  <= RELEASE;
                  gnt2_q <= 1'b0;
                  busy_q <= 1'b0;
                  flag_q <= expire2;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.GNT_IE01     = gnt1_q;
   assign bus.GNT_IE02     = gnt2_q;
   assign bus.BUSY         = busy_q;
   assign bus.TIMEOUT_FLAG = flag_q;
   assign bus.LED_r        = led_q[2];
   assign bus.LED_g        = led_q[1];
   assign bus.LED_b        = led_q[0];
endmodule

// File: tb/tb_arbitro_acesso.sv
// tb/tb_arbitro_acesso.sv - vector table, corner sequences and random run against a reference model
module tb_arbitro_acesso;
   localparam int TIMEOUT = 4;

   logic clk;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   arbitro_acesso_if bus();

   arbitro_acesso #(.TIMEOUT(TIMEOUT), .CNT_W(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       r1, r2;
      logic [1:0] p1, p2;
      logic       d1, d2;
      logic [6:0] exp;   // {gnt1, gnt2, busy, flag, led_r, led_g, led_b}
   } vec_t;

   vec_t tbl[22];

   // Reference: who owns access, how many cycles it has held it, who was served last.
   int         m_owner;
   int         m_held;
   int         m_last;
   logic [2:0] m_led;
   logic       m_flag;

   function automatic vec_t mk(logic r1, logic r2, logic [1:0] p1, logic [1:0] p2,
                               logic d1, logic d2, logic [6:0] exp);
      vec_t v;
      v.r1 = r1; v.r2 = r2; v.p1 = p1; v.p2 = p2; v.d1 = d1; v.d2 = d2; v.exp = exp;
      return v;
   endfunction

   function automatic logic [6:0] obs();
      return {bus.GNT_IE01, bus.GNT_IE02, bus.BUSY, bus.TIMEOUT_FLAG,
              bus.LED_r, bus.LED_g, bus.LED_b};
   endfunction

   function automatic logic [6:0] model_out();
      return {m_owner == 1, m_owner == 2, m_owner != 0, m_flag, m_led};
   endfunction

   task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_owner = 0; m_held = 0; m_last = 2; m_led = 3'b000; m_flag = 1'b0;
   endtask

   task automatic model_step();
      logic r1, r2, d, r;
      int   p1, p2, won;
      r1 = bus.REQ_IE01; r2 = bus.REQ_IE02;
      p1 = int'(bus.PERF_IE01); p2 = int'(bus.PERF_IE02);
      m_flag = 1'b0;
      won = 0;
      if (m_owner != 0) begin
         d = (m_owner == 1) ? bus.DONE_IE01 : bus.DONE_IE02;
         r = (m_owner == 1) ? bus.REQ_IE01  : bus.REQ_IE02;
         m_held++;
         if (d || !r) m_owner = 0;
         else if (m_held >= TIMEOUT) begin
            m_owner = 0;
            m_flag  = 1'b1;
         end
      end else if (r1 && r2) begin
         if (p1 > p2)      begin won = 1; m_led = 3'b001; end
         else if (p1 < p2) begin won = 2; m_led = 3'b100; end
         else              begin won = 3 - m_last; m_led = 3'b010; end
      end else if (r1) won = 1;
      else if (r2) won = 2;
      if (won != 0) begin
         m_owner = won;
         m_held  = 0;
         m_last  = won;
      end
   endtask

   task automatic drive(input logic r1, input logic r2, input logic [1:0] p1,
                        input logic [1:0] p2, input logic d1, input logic d2);
      bus.REQ_IE01 = r1; bus.REQ_IE02 = r2;
      bus.PERF_IE01 = p1; bus.PERF_IE02 = p2;
      bus.DONE_IE01 = d1; bus.DONE_IE02 = d2;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic do_reset();
      drive(0, 0, 2'd0, 2'd0, 0, 0);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
   endtask

   initial begin
      tbl[0]  = mk(0, 0, 2'd0, 2'd0, 0, 0, 7'b0000000);
      tbl[1]  = mk(1, 0, 2'd0, 2'd0, 0, 0, 7'b1010000);
      tbl[2]  = mk(1, 0, 2'd0, 2'd0, 0, 0, 7'b1010000);
      tbl[3]  = mk(1, 0, 2'd0, 2'd0, 1, 0, 7'b0000000);
      tbl[4]  = mk(0, 0, 2'd0, 2'd0, 0, 0, 7'b0000000);
      tbl[5]  = mk(1, 1, 2'd2, 2'd3, 0, 0, 7'b0110100);
      tbl[6]  = mk(1, 1, 2'd2, 2'd3, 0, 1, 7'b0000100);
      tbl[7]  = mk(1, 0, 2'd2, 2'd3, 0, 0, 7'b1010100);
      tbl[8]  = mk(1, 0, 2'd2, 2'd3, 1, 0, 7'b0000100);
      tbl[9]  = mk(0, 1, 2'd0, 2'd0, 0, 0, 7'b0110100);
      tbl[10] = mk(0, 1, 2'd0, 2'd0, 0, 1, 7'b0000100);
      tbl[11] = mk(1, 1, 2'd1, 2'd1, 0, 0, 7'b1010010);
      tbl[12] = mk(1, 1, 2'd1, 2'd1, 1, 0, 7'b0000010);
      tbl[13] = mk(1, 1, 2'd1, 2'd1, 0, 0, 7'b0110010);
      tbl[14] = mk(1, 1, 2'd1, 2'd1, 0, 1, 7'b0000010);
      tbl[15] = mk(1, 1, 2'd1, 2'd1, 0, 0, 7'b1010010);
      tbl[16] = mk(1, 1, 2'd1, 2'd1, 1, 0, 7'b0000010);
      tbl[17] = mk(0, 0, 2'd0, 2'd0, 0, 0, 7'b0000010);
      tbl[18] = mk(0, 1, 2'd0, 2'd0, 0, 0, 7'b0110010);
      tbl[19] = mk(0, 1, 2'd0, 2'd0, 1, 0, 7'b0110010);
      tbl[20] = mk(0, 0, 2'd0, 2'd0, 0, 0, 7'b0000010);
      tbl[21] = mk(0, 0, 2'd0, 2'd0, 0, 0, 7'b0000010);

      reset = 1'b1;
      drive(0, 0, 2'd0, 2'd0, 0, 0);
      #2;
      check("reset_state", obs(), 7'b0000000);
      do_reset();
      check("after_reset", obs(), 7'b0000000);

      for (int i = 0; i < 22; i++) begin
         drive(tbl[i].r1, tbl[i].r2, tbl[i].p1, tbl[i].p2, tbl[i].d1, tbl[i].d2);
         tick();
         check($sformatf("vec%0d", i), obs(), tbl[i].exp);
      end

      // Hold limit: IE01 never signals DONE.
      drive(1, 0, 2'd0, 2'd0, 0, 0);
      for (int i = 0; i < TIMEOUT; i++) begin
         tick();
         check($sformatf("hold_cycle%0d", i), obs(), 7'b1010010);
      end
      tick();
      check("timeout_release", obs(), 7'b0001010);
      tick();
      check("timeout_regrant", obs(), 7'b1010010);
      drive(0, 0, 2'd0, 2'd0, 0, 0);
      tick();
      check("abandon_no_flag", obs(), 7'b0000010);
      tick();
      check("idle_after_abandon", obs(), 7'b0000010);

      // Asynchronous reset in the middle of a grant.
      drive(1, 0, 2'd0, 2'd0, 0, 0);
      tick();
      check("pre_async_grant", obs(), 7'b1010010);
      #3;
      reset = 1'b1;
      #1;
      check("async_reset_drop", obs(), 7'b0000000);
      model_reset();
      #2;
      reset = 1'b0;
      drive(1, 1, 2'd1, 2'd1, 0, 0);
      tick();
      check("tie_after_reset", obs(), 7'b1010010);

      do_reset();
      for (int i = 0; i < 3000; i++) begin
         drive($urandom_range(9) < 7, $urandom_range(9) < 7,
               2'($urandom_range(3)), 2'($urandom_range(3)),
               $urandom_range(5) == 0, $urandom_range(5) == 0);
         tick();
         check($sformatf("rand%0d", i), obs(), model_out());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
